// File: rtl/johnson_seq_checker.sv
// Receive-side integrity monitor for a twisted-ring (Johnson) counter stream:
// decodes each qualified word, flags illegal codes and out-of-order steps, tracks lock.
module johnson_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              jc_in,
    input  logic                          jc_valid,
    output logic [$clog2(2*WIDTH)-1:0]    count,
    output logic                          count_valid,
    output logic                          illegal,
    output logic                          seq_err,
    output logic                          locked,
    output logic [ERR_W-1:0]              err_cnt
);

    localparam int CW = $clog2(2*WIDTH);
    localparam int SW = $clog2(LOCK_CNT+1);
    localparam logic [CW-1:0] LAST_IDX = CW'(2*WIDTH-1);
    localparam logic [SW-1:0] LOCK_STREAK = SW'(LOCK_CNT);

    typedef enum logic [0:0] {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    // Number of ones in the sampled word; always fits in CW bits because WIDTH < 2*WIDTH.
    function automatic logic [CW-1:0] ones_count(input logic [WIDTH-1:0] w);
        logic [CW-1:0] n;
        n = '0;
        for (int k = 0; k < WIDTH; k++) begin
            n = n + CW'(w[k]);
        end
        return n;
    endfunction

    // Reference Johnson code for a state index, built by stepping the twisted ring.
    function automatic logic [WIDTH-1:0] jc_enc(input logic [CW-1:0] idx);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int k = 0; k < 2*WIDTH; k++) begin
            if (k < int'(idx)) begin
                w = {w[WIDTH-2:0], ~w[WIDTH-1]};
            end
        end
        return w;
    endfunction

    state_t            state_r, state_nx_s;
    logic [SW-1:0]     streak_r, streak_nx_s, streak_inc_s;
    logic              have_prev_r, have_prev_nx_s;
    logic [CW-1:0]     prev_r, prev_nx_s;
    logic [CW-1:0]     count_nx_s;
    logic              count_valid_nx_s, illegal_nx_s, seq_err_nx_s;
    logic [ERR_W-1:0]  err_cnt_nx_s, err_cnt_inc_s;
    logic [CW-1:0]     n_s, idx_s, succ_s;
    logic              legal_s, succ_ok_s;

    // Decode: mod-2^CW subtraction yields 2*WIDTH - n since the result is below 2*WIDTH.
    always_comb begin
        n_s       = ones_count(jc_in);
        idx_s     = jc_in[WIDTH-1] ? (CW'(2*WIDTH) - n_s) : n_s;
        legal_s   = (jc_enc(idx_s) == jc_in);
        succ_s    = (prev_r == LAST_IDX) ? {CW{1'b0}} : (prev_r + CW'(1));
        succ_ok_s = !have_prev_r || (idx_s == succ_s);
        streak_inc_s  = (streak_r == LOCK_STREAK) ? streak_r : (streak_r + SW'(1));
        err_cnt_inc_s = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : (err_cnt + ERR_W'(1));
    end

    // Next-state logic for tracking state, lock FSM and all registered outputs.
    always_comb begin
        state_nx_s       = state_r;
        streak_nx_s      = streak_r;
        have_prev_nx_s   = have_prev_r;
        prev_nx_s        = prev_r;
        count_nx_s       = count;
        count_valid_nx_s = 1'b0;
        illegal_nx_s     = 1'b0;
        seq_err_nx_s     = 1'b0;
        err_cnt_nx_s     = err_cnt;
        if (jc_valid) begin
            if (!legal_s) begin
                illegal_nx_s   = 1'b1;
                err_cnt_nx_s   = err_cnt_inc_s;
                streak_nx_s    = {SW{1'b0}};
                have_prev_nx_s = 1'b0;
                state_nx_s     = UNLOCKED;
            end else begin
                count_nx_s       = idx_s;
                count_valid_nx_s = 1'b1;
                have_prev_nx_s   = 1'b1;
                prev_nx_s        = idx_s;
                if (succ_ok_s) begin
                    streak_nx_s = streak_inc_s;
                    case (state_r)
                        UNLOCKED: begin
                            if (streak_inc_s == LOCK_STREAK) begin
                                state_nx_s = LOCKED;
                            end else begin
                                state_nx_s = UNLOCKED;
                            end
                        end
                        LOCKED:   state_nx_s = LOCKED;
                        default:  state_nx_s = UNLOCKED;
                    endcase
                end else begin
                    // Out-of-order word re-syncs: it counts as the first of a new streak.
                    seq_err_nx_s = 1'b1;
                    err_cnt_nx_s = err_cnt_inc_s;
                    streak_nx_s  = SW'(1);
                    state_nx_s   = UNLOCKED;
                end
            end
        end else begin
            state_nx_s = state_r;
        end
    end

    // State and output registers; synchronous reset overrides any sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= UNLOCKED;
            streak_r    <= {SW{1'b0}};
            have_prev_r <= 1'b0;
            prev_r      <= {CW{1'b0}};
            count       <= {CW{1'b0}};
            count_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            err_cnt     <= {ERR_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            streak_r    <= streak_nx_s;
            have_prev_r <= have_prev_nx_s;
            prev_r      <= prev_nx_s;
            count       <= count_nx_s;
            count_valid <= count_valid_nx_s;
            illegal     <= illegal_nx_s;
            seq_err     <= seq_err_nx_s;
            locked      <= (state_nx_s == LOCKED);
            err_cnt     <= err_cnt_nx_s;
        end
    end

endmodule

// File: tb/tb_johnson_seq_checker.sv
// Table-driven bench for johnson_seq_checker (WIDTH=4, LOCK_CNT=3) with a second
// instance at ERR_W=2 to observe error-counter saturation.
module tb_johnson_seq_checker;

    logic       clk;
    logic       reset;
    logic [3:0] jc_in;
    logic       jc_valid;
    logic [2:0] count,  count2;
    logic       count_valid, count_valid2;
    logic       illegal, illegal2;
    logic       seq_err, seq_err2;
    logic       locked, locked2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;

    int checks   = 0;
    int failures = 0;

    johnson_seq_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid),
        .count(count), .count_valid(count_valid), .illegal(illegal),
        .seq_err(seq_err), .locked(locked), .err_cnt(err_cnt)
    );

    johnson_seq_checker #(.WIDTH(4), .LOCK_CNT(3), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .jc_in(jc_in), .jc_valid(jc_valid),
        .count(count2), .count_valid(count_valid2), .illegal(illegal2),
        .seq_err(seq_err2), .locked(locked2), .err_cnt(err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       vld;
        logic [3:0] jc;
        logic [2:0] c;
        logic       cv;
        logic       il;
        logic       se;
        logic       lk;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic vld, input logic [3:0] jc,
                       input logic [2:0] c, input logic cv, input logic il,
                       input logic se, input logic lk, input logic [7:0] e);
        vec_t v;
        v.rst = rst; v.vld = vld; v.jc = jc; v.c = c; v.cv = cv;
        v.il = il; v.se = se; v.lk = lk; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and sample #1 after the rising edge.
    task automatic step(input logic rst, input logic vld, input logic [3:0] jc);
        reset    = rst;
        jc_valid = vld;
        jc_in    = jc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] e2;
        reset = 1'b1; jc_valid = 1'b0; jc_in = 4'b0000;

        // rst vld jc       count cv il se lk err
        add(1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b1, 1'b1, 4'b1111, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b1111, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b1110, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b1100, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b1000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        add(1'b0, 1'b1, 4'b0101, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b1, 4'b0001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b1, 4'b0011, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        add(1'b0, 1'b1, 4'b0111, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
        add(1'b0, 1'b1, 4'b1110, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 8'd2);
        add(1'b0, 1'b1, 4'b1100, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        add(1'b0, 1'b1, 4'b1000, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        add(1'b0, 1'b0, 4'b0101, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
        add(1'b0, 1'b0, 4'b1111, 3'd7, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
        add(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2);
        add(1'b0, 1'b1, 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3);
        add(1'b1, 1'b1, 4'b0001, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        add(1'b0, 1'b1, 4'b0101, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1);
        add(1'b0, 1'b1, 4'b1010, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        add(1'b0, 1'b1, 4'b0110, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
        add(1'b0, 1'b1, 4'b1001, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
        add(1'b0, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].jc);
            e2 = (vecs[i].e > 8'd3) ? 8'd3 : vecs[i].e;
            chk("count",       i, 32'(count),       32'(vecs[i].c));
            chk("count_valid", i, 32'(count_valid), 32'(vecs[i].cv));
            chk("illegal",     i, 32'(illegal),     32'(vecs[i].il));
            chk("seq_err",     i, 32'(seq_err),     32'(vecs[i].se));
            chk("locked",      i, 32'(locked),      32'(vecs[i].lk));
            chk("err_cnt",     i, 32'(err_cnt),     32'(vecs[i].e));
            chk("err_cnt_sat", i, 32'(err_cnt2),    32'(e2));
        end

        // Lock from a mid-sequence start, then hold across a multi-cycle valid gap.
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b1, 4'b0111);
        chk("mid_start_count", 100, 32'(count), 32'd3);
        chk("mid_start_lock",  100, 32'(locked), 32'd0);
        step(1'b0, 1'b1, 4'b1111);
        chk("mid_start_lock",  101, 32'(locked), 32'd0);
        step(1'b0, 1'b1, 4'b1110);
        chk("mid_start_lock",  102, 32'(locked), 32'd1);
        chk("mid_start_count", 102, 32'(count), 32'd5);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 4'b0000);
            chk("gap_lock",  103 + g, 32'(locked), 32'd1);
            chk("gap_cv",    103 + g, 32'(count_valid), 32'd0);
            chk("gap_count", 103 + g, 32'(count), 32'd5);
        end
        step(1'b0, 1'b1, 4'b1100);
        chk("after_gap_count", 106, 32'(count), 32'd6);
        chk("after_gap_lock",  106, 32'(locked), 32'd1);
        chk("after_gap_err",   106, 32'(seq_err), 32'd0);
        step(1'b0, 1'b0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
